// File: rtl/ysyx_22050039_lsu_if.sv
// Handshake bundle between the ysyx_22050039 core, its LSU and the data bus.
// The slave modport is the LSU's view; the master modport is the core plus memory side.
interface ysyx_22050039_lsu_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RD_W = 5
);
   localparam int unsigned NBYTES = XLEN / 8;

   // Request from the execute stage
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [XLEN-1:0]   req_base;
   logic [XLEN-1:0]   req_offset;
   logic [XLEN-1:0]   req_wdata;
   logic [RD_W-1:0]   req_rd;

   // Data bus
   logic              mem_valid;
   logic              mem_ready;
   logic [XLEN-1:0]   mem_addr;
   logic              mem_we;
   logic [XLEN-1:0]   mem_wdata;
   logic [NBYTES-1:0] mem_wmask;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   // Result back to the pipeline
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic [RD_W-1:0]   resp_rd;
   logic              resp_misalign;
   logic              busy;

   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned, req_base, req_offset,
             req_wdata, req_rd, mem_ready, mem_rvalid, mem_rdata, resp_ready,
      output req_ready, mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
             resp_valid, resp_data, resp_rd, resp_misalign, busy
   );

   modport master (
      output req_valid, req_is_store, req_size, req_unsigned, req_base, req_offset,
             req_wdata, req_rd, mem_ready, mem_rvalid, mem_rdata, resp_ready,
      input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
             resp_valid, resp_data, resp_rd, resp_misalign, busy
   );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: one transaction in flight, aligned bus beats,
// lane-shifted store data and sign/zero-extended load results.
module ysyx_22050039_lsu #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NBYTES = XLEN / 8,
   parameter int unsigned RD_W   = 5
) (
   input logic                clk,
   input logic                rst,
   ysyx_22050039_lsu_if.slave lsu
);
   localparam int unsigned OFF_W = $clog2(NBYTES);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   ea_q, ea_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic              is_store_q, is_store_d;
   logic              misalign_q, misalign_d;
   logic [RD_W-1:0]   rd_q, rd_d;

   logic [XLEN-1:0]   ea_new;
   logic [2:0]        align_mask;
   logic              misalign_new;
   logic [OFF_W-1:0]  off;
   logic [7:0]        size_mask;
   logic [NBYTES-1:0] byte_mask;
   logic [XLEN-1:0]   data_mask;
   logic [XLEN-1:0]   load_shift;
   logic [63:0]       load_wide;
   logic [63:0]       load_ext;

   assign off = ea_q[OFF_W-1:0];

   // Effective address of the offered request and its alignment fault
   always_comb begin
      ea_new     = lsu.req_base + lsu.req_offset;
      align_mask = 3'b000;
      unique case (lsu.req_size)
         2'd0: align_mask = 3'b000;
         2'd1: align_mask = 3'b001;
         2'd2: align_mask = 3'b011;
         2'd3: align_mask = 3'b111;
      endcase
      // A dword on a 32-bit bus cannot be carried in one beat
      misalign_new = (|(ea_new[2:0] & align_mask)) || (lsu.req_size == 2'd3 && XLEN == 32);
   end

   // Byte enables and bit mask of the registered access
   always_comb begin
      size_mask = 8'h01;
      unique case (size_q)
         2'd0: size_mask = 8'h01;
         2'd1: size_mask = 8'h03;
         2'd2: size_mask = 8'h0F;
         2'd3: size_mask = 8'hFF;
      endcase
      byte_mask = NBYTES'(size_mask) << off;
      data_mask = '0;
      for (int i = 0; i < NBYTES; i++) begin
         data_mask[8*i +: 8] = {8{size_mask[i % 8]}};
      end
   end

   // Pull the addressed lanes down to bit 0 and extend to 64 bits
   always_comb begin
      load_shift = lsu.mem_rdata >> {off, 3'b000};
      load_wide  = 64'(load_shift);
      load_ext   = load_wide;
      unique case (size_q)
         2'd0: load_ext = unsigned_q ? {56'd0, load_wide[7:0]}
                                     : {{56{load_wide[7]}}, load_wide[7:0]};
         2'd1: load_ext = unsigned_q ? {48'd0, load_wide[15:0]}
                                     : {{48{load_wide[15]}}, load_wide[15:0]};
         2'd2: load_ext = unsigned_q ? {32'd0, load_wide[31:0]}
                                     : {{32{load_wide[31]}}, load_wide[31:0]};
         2'd3: load_ext = load_wide;
      endcase
   end

   // Next-state and transaction register updates
   always_comb begin
      state_d    = state_q;
      ea_d       = ea_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      is_store_d = is_store_q;
      misalign_d = misalign_q;
      rd_d       = rd_q;
      unique case (state_q)
         StIdle: begin
            if (lsu.req_valid) begin
               ea_d       = ea_new;
               wdata_d    = lsu.req_wdata;
               rdata_d    = '0;
               size_d     = lsu.req_size;
               unsigned_d = lsu.req_unsigned;
               is_store_d = lsu.req_is_store;
               misalign_d = misalign_new;
               rd_d       = lsu.req_rd;
               state_d    = misalign_new ? StResp : StReq;
            end
         end
         StReq: begin
            if (lsu.mem_ready) state_d = is_store_q ? StResp : StWait;
         end
         StWait: begin
            if (lsu.mem_rvalid) begin
               rdata_d = XLEN'(load_ext);
               state_d = StResp;
            end
         end
         StResp: begin
            if (lsu.resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and transaction registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ea_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         is_store_q <= 1'b0;
         misalign_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         ea_q       <= ea_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         is_store_q <= is_store_d;
         misalign_q <= misalign_d;
         rd_q       <= rd_d;
      end
   end

   // Outputs decoded from state; everything is forced low while rst is high
   always_comb begin
      lsu.req_ready     = 1'b0;
      lsu.busy          = 1'b0;
      lsu.mem_valid     = 1'b0;
      lsu.mem_addr      = '0;
      lsu.mem_we        = 1'b0;
      lsu.mem_wmask     = '0;
      lsu.mem_wdata     = '0;
      lsu.resp_valid    = 1'b0;
      lsu.resp_data     = '0;
      lsu.resp_rd       = '0;
      lsu.resp_misalign = 1'b0;
      if (!rst) begin
         lsu.req_ready = (state_q == StIdle);
         lsu.busy      = (state_q != StIdle);
         if (state_q == StReq) begin
            lsu.mem_valid = 1'b1;
            lsu.mem_addr  = ea_q & ~XLEN'(NBYTES - 1);
            lsu.mem_we    = is_store_q;
            if (is_store_q) begin
               lsu.mem_wmask = byte_mask;
               lsu.mem_wdata = (wdata_q & data_mask) << {off, 3'b000};
            end
         end
         if (state_q == StResp) begin
            lsu.resp_valid    = 1'b1;
            lsu.resp_data     = rdata_q;
            lsu.resp_rd       = rd_q;
            lsu.resp_misalign = misalign_q;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for ysyx_22050039_lsu at XLEN = 64: vector table plus
// hand-written backpressure and reset-abandon sequences.
module tb_ysyx_22050039_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   ysyx_22050039_lsu_if #(.XLEN(64), .RD_W(5)) lsu_bus ();

   ysyx_22050039_lsu #(.XLEN(64), .RD_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .lsu (lsu_bus)
   );

   typedef struct packed {
      logic        is_store;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] base;
      logic [63:0] offset;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic [63:0] rdata;
      logic        exp_mem;
      logic [63:0] exp_addr;
      logic        exp_we;
      logic [7:0]  exp_mask;
      logic [63:0] exp_wdata;
      logic [63:0] exp_data;
      logic        exp_mis;
      logic [3:0]  exp_cyc;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk_ld(input logic [1:0] size, input logic uns,
                                  input logic [63:0] base, input logic [63:0] off,
                                  input logic [4:0] rd, input logic [63:0] rdata,
                                  input logic [63:0] addr, input logic [63:0] data);
      vec_t v;
      v = '0;
      v.size = size; v.uns = uns; v.base = base; v.offset = off; v.rd = rd;
      v.rdata = rdata; v.exp_mem = 1'b1; v.exp_addr = addr; v.exp_data = data;
      v.exp_cyc = 4'd3;
      return v;
   endfunction

   function automatic vec_t mk_st(input logic [1:0] size, input logic [63:0] base,
                                  input logic [63:0] off, input logic [4:0] rd,
                                  input logic [63:0] wdata, input logic [63:0] addr,
                                  input logic [7:0] mask, input logic [63:0] mwdata);
      vec_t v;
      v = '0;
      v.is_store = 1'b1; v.size = size; v.base = base; v.offset = off; v.rd = rd;
      v.wdata = wdata; v.rdata = 64'hFFFF_FFFF_FFFF_FFFF; v.exp_mem = 1'b1;
      v.exp_addr = addr; v.exp_we = 1'b1; v.exp_mask = mask; v.exp_wdata = mwdata;
      v.exp_cyc = 4'd2;
      return v;
   endfunction

   function automatic vec_t mk_mis(input logic is_store, input logic [1:0] size,
                                   input logic [63:0] base, input logic [63:0] off,
                                   input logic [4:0] rd);
      vec_t v;
      v = '0;
      v.is_store = is_store; v.size = size; v.base = base; v.offset = off; v.rd = rd;
      v.wdata = 64'h1234_5678_9ABC_DEF0; v.exp_mis = 1'b1; v.exp_cyc = 4'd1;
      return v;
   endfunction

   // One transaction with zero-wait bus, rvalid one cycle after mem_ready, resp_ready = 1
   task automatic run_txn(input vec_t v, input string tag);
      int          cyc;
      int          mem_cyc;
      int          resp_cyc;
      logic        pend;
      logic [63:0] m_addr, m_wdata, r_data;
      logic [7:0]  m_mask;
      logic        m_we, r_mis;
      logic [4:0]  r_rd;
      cyc = 0; mem_cyc = 0; resp_cyc = 0; pend = 1'b0;
      m_addr = '0; m_wdata = '0; m_mask = '0; m_we = 1'b0;
      r_data = '0; r_mis = 1'b0; r_rd = '0;
      @(negedge clk);
      lsu_bus.req_is_store = v.is_store;
      lsu_bus.req_size     = v.size;
      lsu_bus.req_unsigned = v.uns;
      lsu_bus.req_base     = v.base;
      lsu_bus.req_offset   = v.offset;
      lsu_bus.req_wdata    = v.wdata;
      lsu_bus.req_rd       = v.rd;
      lsu_bus.mem_rdata    = v.rdata;
      lsu_bus.mem_ready    = 1'b1;
      lsu_bus.resp_ready   = 1'b1;
      lsu_bus.mem_rvalid   = 1'b0;
      lsu_bus.req_valid    = 1'b1;
      check({tag, " req_ready"}, 64'(lsu_bus.req_ready), 64'd1);
      @(posedge clk);
      #1 lsu_bus.req_valid = 1'b0;
      while (resp_cyc == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (lsu_bus.mem_valid && mem_cyc == 0) begin
            mem_cyc = cyc;
            m_addr  = lsu_bus.mem_addr;
            m_we    = lsu_bus.mem_we;
            m_mask  = lsu_bus.mem_wmask;
            m_wdata = lsu_bus.mem_wdata;
         end
         if (lsu_bus.resp_valid) begin
            resp_cyc = cyc;
            r_data   = lsu_bus.resp_data;
            r_rd     = lsu_bus.resp_rd;
            r_mis    = lsu_bus.resp_misalign;
         end
         lsu_bus.mem_rvalid = pend;
         pend = lsu_bus.mem_valid && lsu_bus.mem_ready && !lsu_bus.mem_we;
      end
      lsu_bus.mem_rvalid = 1'b0;
      check({tag, " resp_cycle"}, 64'(resp_cyc), 64'(v.exp_cyc));
      check({tag, " resp_data"}, r_data, v.exp_data);
      check({tag, " resp_rd"}, 64'(r_rd), 64'(v.rd));
      check({tag, " resp_misalign"}, 64'(r_mis), 64'(v.exp_mis));
      check({tag, " mem_cycle"}, 64'(mem_cyc), v.exp_mem ? 64'd1 : 64'd0);
      if (v.exp_mem) begin
         check({tag, " mem_addr"}, m_addr, v.exp_addr);
         check({tag, " mem_we"}, 64'(m_we), 64'(v.exp_we));
         check({tag, " mem_wmask"}, 64'(m_mask), 64'(v.exp_mask));
         check({tag, " mem_wdata"}, m_wdata, v.exp_wdata);
      end
   endtask

   vec_t vecs[17];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = mk_ld(2'd0, 1'b0, 64'h8000_0000, 64'd7, 5'd1, 64'hF122_3344_5566_7788,
                       64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF1);
      vecs[1]  = mk_ld(2'd0, 1'b1, 64'h8000_0000, 64'd7, 5'd2, 64'hF122_3344_5566_7788,
                       64'h8000_0000, 64'h0000_0000_0000_00F1);
      vecs[2]  = mk_st(2'd2, 64'h8000_0100, 64'd4, 5'd3, 64'hDEAD_BEEF_CAFE_BABE,
                       64'h8000_0100, 8'hF0, 64'hCAFE_BABE_0000_0000);
      vecs[3]  = mk_mis(1'b0, 2'd1, 64'h8000_0000, 64'd1, 5'd5);
      vecs[4]  = mk_ld(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 5'd6,
                       64'h0000_0000_8000_0000, 64'h8, 64'hFFFF_FFFF_8000_0000);
      vecs[5]  = mk_ld(2'd1, 1'b0, 64'h8000_0000, 64'd6, 5'd7, 64'h8001_0000_0000_0000,
                       64'h8000_0000, 64'hFFFF_FFFF_FFFF_8001);
      vecs[6]  = mk_ld(2'd1, 1'b1, 64'h8000_0000, 64'd6, 5'd8, 64'h8001_0000_0000_0000,
                       64'h8000_0000, 64'h0000_0000_0000_8001);
      vecs[7]  = mk_st(2'd0, 64'h8000_0000, 64'd3, 5'd9, 64'h1122_3344_5566_77AB,
                       64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000);
      vecs[8]  = mk_st(2'd3, 64'h8000_0010, 64'd0, 5'd10, 64'h0123_4567_89AB_CDEF,
                       64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
      vecs[9]  = mk_ld(2'd3, 1'b1, 64'h8000_0010, 64'd0, 5'd11, 64'h8877_6655_4433_2211,
                       64'h8000_0010, 64'h8877_6655_4433_2211);
      vecs[10] = mk_ld(2'd2, 1'b1, 64'h8000_0000, 64'd4, 5'd12, 64'h89AB_CDEF_0000_0000,
                       64'h8000_0000, 64'h0000_0000_89AB_CDEF);
      vecs[11] = mk_mis(1'b1, 2'd3, 64'h8000_0000, 64'd4, 5'd13);
      vecs[12] = mk_st(2'd1, 64'h8000_0000, 64'd2, 5'd14, 64'h1234_5678_9ABC_BEEF,
                       64'h8000_0000, 8'h0C, 64'h0000_0000_BEEF_0000);
      vecs[13] = mk_ld(2'd2, 1'b0, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, 5'd15,
                       64'h7FFF_FFFF_0000_0000, 64'h8000_0008, 64'h0000_0000_7FFF_FFFF);
      vecs[14] = mk_ld(2'd0, 1'b0, 64'h8000_0000, 64'd0, 5'd16, 64'h1234_5678_9ABC_DE80,
                       64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      vecs[15] = mk_mis(1'b0, 2'd2, 64'h8000_0000, 64'd2, 5'd17);
      vecs[16] = mk_st(2'd0, 64'h8000_0000, 64'd7, 5'd18, 64'h0000_0000_0000_005A,
                       64'h8000_0000, 8'h80, 64'h5A00_0000_0000_0000);

      lsu_bus.req_valid = 1'b0;    lsu_bus.req_is_store = 1'b0; lsu_bus.req_size = 2'd0;
      lsu_bus.req_unsigned = 1'b0; lsu_bus.req_base = '0;       lsu_bus.req_offset = '0;
      lsu_bus.req_wdata = '0;      lsu_bus.req_rd = '0;         lsu_bus.mem_ready = 1'b0;
      lsu_bus.mem_rvalid = 1'b0;   lsu_bus.mem_rdata = '0;      lsu_bus.resp_ready = 1'b0;

      // Reset: all outputs low while rst is high, ready the cycle after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 64'(lsu_bus.req_ready), 64'd0);
      check("rst mem_valid", 64'(lsu_bus.mem_valid), 64'd0);
      check("rst resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
      check("rst busy", 64'(lsu_bus.busy), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post-rst req_ready", 64'(lsu_bus.req_ready), 64'd1);
      check("post-rst busy", 64'(lsu_bus.busy), 64'd0);

      for (int i = 0; i < 17; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: ld held 3 cycles by mem_ready, stray rvalid during REQ ignored
      @(negedge clk);
      lsu_bus.req_is_store = 1'b0; lsu_bus.req_size = 2'd3; lsu_bus.req_unsigned = 1'b0;
      lsu_bus.req_base = 64'h8000_0000; lsu_bus.req_offset = 64'h20; lsu_bus.req_rd = 5'd20;
      lsu_bus.mem_ready = 1'b0; lsu_bus.resp_ready = 1'b0; lsu_bus.req_valid = 1'b1;
      check("bp req_ready", 64'(lsu_bus.req_ready), 64'd1);
      @(posedge clk);
      #1 lsu_bus.req_valid = 1'b0;
      lsu_bus.mem_rvalid = 1'b1;
      lsu_bus.mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) lsu_bus.mem_ready = 1'b1;
         @(negedge clk);
         check($sformatf("bp c%0d mem_valid", c), 64'(lsu_bus.mem_valid), 64'd1);
         check($sformatf("bp c%0d mem_addr", c), lsu_bus.mem_addr, 64'h8000_0020);
         @(posedge clk);
         #1;
      end
      lsu_bus.mem_ready  = 1'b0;
      lsu_bus.mem_rdata  = 64'h0011_2233_4455_6677;
      @(negedge clk);
      check("bp wait resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
      check("bp wait mem_valid", 64'(lsu_bus.mem_valid), 64'd0);
      @(posedge clk);
      #1 lsu_bus.mem_rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("bp hold%0d resp_valid", c), 64'(lsu_bus.resp_valid), 64'd1);
         check($sformatf("bp hold%0d resp_data", c), lsu_bus.resp_data,
               64'h0011_2233_4455_6677);
         check($sformatf("bp hold%0d req_ready", c), 64'(lsu_bus.req_ready), 64'd0);
         check($sformatf("bp hold%0d busy", c), 64'(lsu_bus.busy), 64'd1);
         @(posedge clk);
         #1;
      end
      lsu_bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp final resp_valid", 64'(lsu_bus.resp_valid), 64'd1);
      check("bp final resp_rd", 64'(lsu_bus.resp_rd), 64'd20);
      @(negedge clk);
      check("bp idle req_ready", 64'(lsu_bus.req_ready), 64'd1);
      check("bp idle busy", 64'(lsu_bus.busy), 64'd0);

      // Reset in WAIT, then a late rvalid must not produce a response
      lsu_bus.req_size = 2'd3; lsu_bus.req_base = 64'h8000_0008; lsu_bus.req_offset = '0;
      lsu_bus.req_rd = 5'd21; lsu_bus.mem_ready = 1'b1; lsu_bus.req_valid = 1'b1;
      @(posedge clk);
      #1 lsu_bus.req_valid = 1'b0;
      @(negedge clk);
      check("rmid mem_valid", 64'(lsu_bus.mem_valid), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rmid rst req_ready", 64'(lsu_bus.req_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      lsu_bus.mem_rvalid = 1'b1;
      lsu_bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      check("rmid resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
      check("rmid mem_valid after", 64'(lsu_bus.mem_valid), 64'd0);
      check("rmid req_ready", 64'(lsu_bus.req_ready), 64'd1);
      @(posedge clk);
      #1 lsu_bus.mem_rvalid = 1'b0;
      @(negedge clk);
      check("rmid later resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
      check("rmid later busy", 64'(lsu_bus.busy), 64'd0);
      run_txn(mk_ld(2'd3, 1'b0, 64'h8000_0008, 64'd0, 5'd22, 64'h0123_4567_89AB_CDEF,
                    64'h8000_0008, 64'h0123_4567_89AB_CDEF), "after-rst ld");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
